// File: rtl/ctrl_step_sequencer.sv
// Step sequencer for the multicycle RISC controller: owns the step counter, decodes the
// instruction class at the decode step, and produces Buff_PC / Flag / Halted / Illegal.
module ctrl_step_sequencer #(
  parameter int CNT_W     = 3,
  parameter int STEPS_LI  = 3,
  parameter int STEPS_ALU = 4,
  parameter int STEPS_LD  = 5,
  parameter int STEPS_ST  = 4,
  parameter int STEPS_BR  = 3,
  parameter int STEPS_JMP = 4,
  parameter int FLAG_STEP = 2
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             Resume,
  input  logic [4:0]       InsM,
  input  logic [1:0]       InsL,
  output logic [CNT_W-1:0] Cnt,
  output logic             Buff_PC,
  output logic             Flag,
  output logic             Halted,
  output logic             Illegal
);

  localparam int STEPS_CAP = 1 << CNT_W;

  if (STEPS_LI < 2 || STEPS_LI > STEPS_CAP || STEPS_ALU < 2 || STEPS_ALU > STEPS_CAP ||
      STEPS_LD < 2 || STEPS_LD > STEPS_CAP || STEPS_ST < 2 || STEPS_ST > STEPS_CAP ||
      STEPS_BR < 2 || STEPS_BR > STEPS_CAP || STEPS_JMP < 2 || STEPS_JMP > STEPS_CAP) begin : g_bad_steps
    $error("ctrl_step_sequencer: every STEPS_* must lie in 2..2**CNT_W");
  end
  if (FLAG_STEP < 2 || FLAG_STEP > STEPS_ALU - 1) begin : g_bad_flag
    $error("ctrl_step_sequencer: FLAG_STEP must lie in 2..STEPS_ALU-1");
  end

  localparam logic [CNT_W-1:0] DEC_STEP  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FLAG_CNT  = CNT_W'(FLAG_STEP);

  typedef enum logic {S_RUN, S_HALT} state_t;
  typedef enum logic [3:0] {C_NONE, C_LI, C_ALU, C_LD, C_ST, C_BR, C_JMP, C_HLT, C_ILL} cls_t;

  state_t           state, state_nxt;
  cls_t             cls, cls_nxt, cls_eff;
  logic [CNT_W-1:0] cnt_nxt, last;

  function automatic cls_t decode(input logic [4:0] m, input logic [1:0] l);
    cls_t c;
    c = C_ILL;
    case (m)
      5'b00001, 5'b00010, 5'b01011:         c = C_LI;
      5'b11100: c = (l == 2'b00) ? C_LI : (l == 2'b01) ? C_HLT : C_ILL;
      5'b00000, 5'b00111, 5'b01000:         c = C_ALU;
      5'b00110: c = (l == 2'b01) ? C_ALU : (l == 2'b00) ? C_ST : C_ILL;
      5'b00011, 5'b00100:                   c = C_LD;
      5'b00101:                             c = C_ST;
      5'b11000, 5'b11001:                   c = C_BR;
      5'b10000, 5'b10001, 5'b10010, 5'b10011: c = C_JMP;
      default:                              c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] last_step(input cls_t c);
    logic [CNT_W-1:0] n;
    case (c)
      C_LI:    n = CNT_W'(STEPS_LI - 1);
      C_ALU:   n = CNT_W'(STEPS_ALU - 1);
      C_LD:    n = CNT_W'(STEPS_LD - 1);
      C_ST:    n = CNT_W'(STEPS_ST - 1);
      C_BR:    n = CNT_W'(STEPS_BR - 1);
      C_JMP:   n = CNT_W'(STEPS_JMP - 1);
      default: n = DEC_STEP;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= S_RUN;
      Cnt   <= '0;
      cls   <= C_NONE;
    end else begin
      state <= state_nxt;
      Cnt   <= cnt_nxt;
      cls   <= cls_nxt;
    end
  end

  // The decode step uses the live opcode so the class length takes effect immediately.
  always_comb begin
    cls_eff   = (Cnt == DEC_STEP) ? decode(InsM, InsL) : cls;
    last      = last_step(cls_eff);
    state_nxt = state;
    cnt_nxt   = Cnt;
    cls_nxt   = cls;
    Buff_PC   = 1'b0;
    Flag      = 1'b0;
    Illegal   = 1'b0;
    if (!Rst) begin
      if (state == S_HALT) begin
        cnt_nxt = '0;
        if (Resume) begin
          Buff_PC   = 1'b1;
          state_nxt = S_RUN;
        end
      end else if (!Stall) begin
        if (Cnt == DEC_STEP) cls_nxt = cls_eff;
        Illegal = (Cnt == DEC_STEP) && (cls_eff == C_ILL);
        Flag    = (cls_eff == C_ALU) && (Cnt == FLAG_CNT);
        if ((Cnt == DEC_STEP) && (cls_eff == C_HLT)) begin
          state_nxt = S_HALT;
          cnt_nxt   = '0;
        end else if (Cnt >= last) begin
          Buff_PC = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = Cnt + DEC_STEP;
        end
      end
    end
  end

  assign Halted = (state == S_HALT);

endmodule

// File: tb/tb_ctrl_step_sequencer.sv
// Bench for ctrl_step_sequencer: directed vector table, an LD-length corner on a wider
// instance, and random traffic against an instruction-level reference model.
module tb_ctrl_step_sequencer;

  logic       clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Stall = 1'b0;
  logic       Resume = 1'b0;
  logic [4:0] InsM = 5'b00000;
  logic [1:0] InsL = 2'b00;

  logic [2:0] cnt_a;
  logic       buff_a, flag_a, halt_a, ill_a;
  logic [3:0] cnt_b;
  logic       buff_b, flag_b, halt_b, ill_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  ctrl_step_sequencer dut_a (
    .clk(clk), .Rst(Rst), .Stall(Stall), .Resume(Resume), .InsM(InsM), .InsL(InsL),
    .Cnt(cnt_a), .Buff_PC(buff_a), .Flag(flag_a), .Halted(halt_a), .Illegal(ill_a)
  );

  ctrl_step_sequencer #(.CNT_W(4), .STEPS_LD(9)) dut_b (
    .clk(clk), .Rst(Rst), .Stall(Stall), .Resume(Resume), .InsM(InsM), .InsL(InsL),
    .Cnt(cnt_b), .Buff_PC(buff_b), .Flag(flag_b), .Halted(halt_b), .Illegal(ill_b)
  );

  // Instruction-level model: where we are in the current instruction and how long it is.
  typedef struct {
    int step;
    int len;
    bit alu;
    bit halted;
  } mstate_t;

  mstate_t ms_a = '{0, 0, 1'b0, 1'b0};
  mstate_t ms_b = '{0, 0, 1'b0, 1'b0};

  function automatic logic [7:0] pk(input int c, input bit b, input bit f, input bit h, input bit i);
    return {4'(c), b, f, h, i};
  endfunction

  function automatic void classify(input logic [4:0] m, input logic [1:0] l, input int ld,
                                   output int len, output bit alu, output bit hlt, output bit ill);
    len = 2; alu = 1'b0; hlt = 1'b0; ill = 1'b0;
    if (m inside {5'b00001, 5'b00010, 5'b01011} || (m == 5'b11100 && l == 2'b00)) len = 3;
    else if (m inside {5'b00000, 5'b00111, 5'b01000} || (m == 5'b00110 && l == 2'b01)) begin
      len = 4; alu = 1'b1;
    end
    else if (m inside {5'b00011, 5'b00100}) len = ld;
    else if (m == 5'b00101 || (m == 5'b00110 && l == 2'b00)) len = 4;
    else if (m inside {5'b11000, 5'b11001}) len = 3;
    else if (m >= 5'b10000 && m <= 5'b10011) len = 4;
    else if (m == 5'b11100 && l == 2'b01) hlt = 1'b1;
    else ill = 1'b1;
  endfunction

  task automatic model_step(input mstate_t s, input int ld, output mstate_t n, output logic [7:0] e);
    bit b, f, i, alu, hlt, ill;
    int len;
    b = 1'b0; f = 1'b0; i = 1'b0;
    n = s;
    if (Rst) begin
      n = '{0, 0, 1'b0, 1'b0};
    end else if (s.halted) begin
      if (Resume) begin
        b = 1'b1;
        n.halted = 1'b0;
      end
    end else if (!Stall) begin
      hlt = 1'b0;
      if (s.step == 1) begin
        classify(InsM, InsL, ld, len, alu, hlt, ill);
        i = ill;
        n.len = len;
        n.alu = alu;
      end
      if (hlt) begin
        n.halted = 1'b1;
        n.step = 0;
      end else begin
        f = n.alu && (s.step == 2);
        b = (s.step == n.len - 1);
        n.step = b ? 0 : s.step + 1;
      end
    end
    e = pk(s.step, b, f, s.halted, i);
  endtask

  task automatic compare(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got cnt=%0d bpc=%b flag=%b halt=%b ill=%b, want cnt=%0d bpc=%b flag=%b halt=%b ill=%b",
               name, cyc, got[7:4], got[3], got[2], got[1], got[0],
               want[7:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic res, input logic [4:0] m,
                       input logic [1:0] l, output logic [7:0] got_a);
    logic [7:0] ea, eb;
    mstate_t na, nb;
    @(negedge clk);
    Rst = r; Stall = s; Resume = res; InsM = m; InsL = l;
    #2;
    cyc++;
    model_step(ms_a, 5, na, ea);
    model_step(ms_b, 9, nb, eb);
    got_a = {1'b0, cnt_a, buff_a, flag_a, halt_a, ill_a};
    compare("model_a", got_a, ea);
    compare("model_b", {cnt_b, buff_b, flag_b, halt_b, ill_b}, eb);
    ms_a = na;
    ms_b = nb;
  endtask

  typedef struct {
    logic       r, s, res;
    logic [4:0] m;
    logic [1:0] l;
    logic [7:0] e;
  } vec_t;

  vec_t vecs[36];
  logic [6:0] ops[16] = '{7'b00001_00, 7'b01011_00, 7'b11100_00, 7'b00000_10, 7'b00111_00,
                          7'b00110_01, 7'b00011_00, 7'b00100_00, 7'b00101_00, 7'b00110_00,
                          7'b11000_00, 7'b11001_00, 7'b10010_00, 7'b10011_00, 7'b11100_01,
                          7'b11100_10};

  initial begin
    logic [7:0] got;
    logic [6:0] op;
    bit seen;
    vecs[0]  = '{1, 0, 0, 5'b00000, 2'b00, pk(0, 0, 0, 0, 0)};
    vecs[1]  = '{1, 0, 0, 5'b00000, 2'b00, pk(0, 0, 0, 0, 0)};
    vecs[2]  = '{0, 0, 0, 5'b00000, 2'b00, pk(0, 0, 0, 0, 0)};
    vecs[3]  = '{0, 0, 0, 5'b00000, 2'b00, pk(1, 0, 0, 0, 0)};
    vecs[4]  = '{0, 0, 0, 5'b00000, 2'b00, pk(2, 0, 1, 0, 0)};
    vecs[5]  = '{0, 0, 0, 5'b00000, 2'b00, pk(3, 1, 0, 0, 0)};
    vecs[6]  = '{0, 0, 0, 5'b00100, 2'b00, pk(0, 0, 0, 0, 0)};
    vecs[7]  = '{0, 0, 0, 5'b00100, 2'b00, pk(1, 0, 0, 0, 0)};
    vecs[8]  = '{0, 0, 0, 5'b00100, 2'b00, pk(2, 0, 0, 0, 0)};
    vecs[9]  = '{0, 0, 0, 5'b00100, 2'b00, pk(3, 0, 0, 0, 0)};
    vecs[10] = '{0, 0, 0, 5'b00100, 2'b00, pk(4, 1, 0, 0, 0)};
    vecs[11] = '{0, 0, 0, 5'b11000, 2'b00, pk(0, 0, 0, 0, 0)};
    vecs[12] = '{0, 0, 0, 5'b11000, 2'b00, pk(1, 0, 0, 0, 0)};
    vecs[13] = '{0, 0, 0, 5'b11000, 2'b00, pk(2, 1, 0, 0, 0)};
    vecs[14] = '{0, 0, 0, 5'b00111, 2'b00, pk(0, 0, 0, 0, 0)};
    vecs[15] = '{0, 0, 0, 5'b00111, 2'b00, pk(1, 0, 0, 0, 0)};
    vecs[16] = '{0, 1, 0, 5'b00111, 2'b00, pk(2, 0, 0, 0, 0)};
    vecs[17] = '{0, 1, 0, 5'b00111, 2'b00, pk(2, 0, 0, 0, 0)};
    vecs[18] = '{0, 1, 0, 5'b00111, 2'b00, pk(2, 0, 0, 0, 0)};
    vecs[19] = '{0, 0, 0, 5'b00111, 2'b00, pk(2, 0, 1, 0, 0)};
    vecs[20] = '{0, 0, 0, 5'b00111, 2'b00, pk(3, 1, 0, 0, 0)};
    vecs[21] = '{0, 0, 0, 5'b11100, 2'b01, pk(0, 0, 0, 0, 0)};
    vecs[22] = '{0, 0, 0, 5'b11100, 2'b01, pk(1, 0, 0, 0, 0)};
    vecs[23] = '{0, 1, 0, 5'b11100, 2'b01, pk(0, 0, 0, 1, 0)};
    vecs[24] = '{0, 0, 0, 5'b11100, 2'b01, pk(0, 0, 0, 1, 0)};
    vecs[25] = '{0, 0, 0, 5'b11100, 2'b01, pk(0, 0, 0, 1, 0)};
    vecs[26] = '{0, 0, 0, 5'b11100, 2'b01, pk(0, 0, 0, 1, 0)};
    vecs[27] = '{0, 0, 0, 5'b11100, 2'b01, pk(0, 0, 0, 1, 0)};
    vecs[28] = '{0, 0, 1, 5'b11100, 2'b01, pk(0, 1, 0, 1, 0)};
    vecs[29] = '{0, 0, 0, 5'b11111, 2'b00, pk(0, 0, 0, 0, 0)};
    vecs[30] = '{0, 0, 0, 5'b11111, 2'b00, pk(1, 1, 0, 0, 1)};
    vecs[31] = '{0, 0, 1, 5'b00000, 2'b00, pk(0, 0, 0, 0, 0)};
    vecs[32] = '{0, 0, 0, 5'b00000, 2'b00, pk(1, 0, 0, 0, 0)};
    vecs[33] = '{1, 0, 0, 5'b00000, 2'b00, pk(2, 0, 0, 0, 0)};
    vecs[34] = '{0, 0, 0, 5'b00000, 2'b00, pk(0, 0, 0, 0, 0)};
    vecs[35] = '{0, 0, 0, 5'b00000, 2'b00, pk(1, 0, 0, 0, 0)};

    for (int i = 0; i < 36; i++) begin
      cycle(vecs[i].r, vecs[i].s, vecs[i].res, vecs[i].m, vecs[i].l, got);
      compare($sformatf("vec%0d", i), got, vecs[i].e);
    end

    // Long LD on the wide instance must retire at Cnt=8.
    cycle(1'b1, 1'b0, 1'b0, 5'b00011, 2'b00, got);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 5'b00011, 2'b00, got);
      if (buff_b) begin
        seen = 1'b1;
        compare("ld9_last", {cnt_b, 4'b1000}, {4'd8, 4'b1000});
      end
    end
    if (!seen) compare("ld9_timeout", {7'd0, seen}, 8'd1);

    for (int k = 0; k < 3000; k++) begin
      op = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 15)] : 7'($urandom());
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            op[6:2], op[1:0], got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
